io_in_filter: RTL and testbench
===============================

Name: io_in_filter

Overview:
Conditions the raw FPGA input pins before they reach the io register block's io_in port. Per bit, it does three things:
- synchronises the pin into clk with a flop chain;
- debounces it with a saturating stability counter;
- produces one-cycle rise/fall pulses.

Its io_in output connects directly to io.io_in.

Parameters:
WIDTH, 32, number of input pins / io_in bits
SYNC_STAGES, 2, synchroniser flop depth (>=2)
DEBOUNCE_CYCLES, 16, consecutive stable synchronised cycles needed before a change is accepted (>=1)
RESET_VAL, 32'b0, value of the synchroniser chain and io_in after reset

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
pins_in  input  WIDTH  raw asynchronous pins
io_in  output  WIDTH  debounced stable value, to io.io_in
rise  output  WIDTH  one-cycle pulse, bit accepted 0->1
fall  output  WIDTH  one-cycle pulse, bit accepted 1->0
edge_clr  input  WIDTH  write-one-to-clear for edge_flags (optional feature)
edge_flags  output  WIDTH  sticky edge flags (optional feature)

Behaviour:
- Interface: one clock, clk; reset rstn is asynchronous, active-low. All flops reset on negedge rstn.
- Reset values:
  - sync chain = RESET_VAL; io_in = RESET_VAL;
  - counters = 0; rise = fall = 0; edge_flags = 0.
- Synchroniser: pins_in passes through SYNC_STAGES flops; syn = last stage. No logic between stages.
- Per-bit debounce, evaluated every clk edge:
  - syn == io_in: cnt <= 0; no pulse.
  - syn != io_in and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - syn != io_in and cnt == DEBOUNCE_CYCLES-1: io_in <= syn; cnt <= 0; rise/fall <= 1 per direction.
- Counter width: clog2(DEBOUNCE_CYCLES) (min 1). The counter never exceeds DEBOUNCE_CYCLES-1, so it never wraps.
- rise/fall: registered; high exactly in the first cycle io_in shows the new value; low otherwise. rise and fall are never both set for one bit.
- Latency:
  - pin step to syn change = SYNC_STAGES cycles;
  - syn change to io_in change = DEBOUNCE_CYCLES cycles;
  - total = SYNC_STAGES + DEBOUNCE_CYCLES.
  - DEBOUNCE_CYCLES=1: io_in follows syn with one cycle delay (no filtering).
- Glitches: a syn excursion shorter than DEBOUNCE_CYCLES cycles is discarded. The counter returns to 0 on the first matching cycle, and no partial credit is kept.
- Bits are fully independent; simultaneous changes on any subset behave per-bit.
- Reset mid-count: counters clear and io_in returns to RESET_VAL immediately (async). After rstn deasserts, a pin differing from RESET_VAL is accepted after the full latency and pulses rise/fall.

Optional Feature:
- Macro: IO_EDGE_LATCH_EN.
- Defined:
  - edge_flags[i] <= 1 on rise[i]|fall[i].
  - edge_flags[i] <= 0 when edge_clr[i]=1 and no new pulse that cycle.
  - Set and clear in the same cycle: set wins, so no event is lost.
- Undefined: edge_flags tied to 0, edge_clr ignored. Ports remain so instantiation is unchanged.

Decomposition:
- include/consts.vh holds:
  - default DEBOUNCE_CYCLES and SYNC_STAGES;
  - IO_PIN_WIDTH = 32.
- One natural sub-module, io_debounce_bit: synchroniser, counter, stable flop and pulse logic for one bit. The top generate-instantiates WIDTH copies and adds the optional flag register.

Test Plan:
All tests use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_VAL=0.
1. Reset: rstn=0 with pins_in=32'hFFFF_FFFF -> io_in=0, rise=fall=0. Release at cycle 0 -> io_in=32'hFFFF_FFFF at cycle 6; rise=32'hFFFF_FFFF for cycle 6 only.
2. pins_in[0] steps 0->1 at cycle 0 and holds -> io_in[0]=1 from cycle 6; rise[0]=1 only in cycle 6; fall stays 0.
3. pins_in[3] pulses high for 3 cycles, then low -> io_in[3] stays 0; rise[3]/fall[3] never assert. A 4-cycle pulse -> io_in[3] high for exactly 4 cycles, with rise[3] then fall[3].
4. pins_in[5] goes high at cycle 0; rstn pulses low at cycle 4 for 1 cycle -> io_in[5] stays 0 through reset. It goes 1 exactly 6 cycles after the first clk edge following rstn release.
5. pins_in = 32'hA5A5_0000 -> 32'h5A5A_0001 in one cycle -> io_in updates all bits together after 6 cycles; rise=32'h5A5A_0001, fall=32'hA5A5_0000 in the same cycle.
6. With IO_EDGE_LATCH_EN:
   - bit 2 rises -> edge_flags[2]=1 and holds;
   - edge_clr[2]=1 -> edge_flags[2]=0 next cycle;
   - edge_clr[2]=1 in the same cycle as a new fall[2] -> edge_flags[2] stays 1.
   Without the macro, edge_flags reads 0 throughout.

Source files
------------

// File: rtl/io_in_filter_pkg.sv
// Shared constants and helpers for the input-pin conditioning block.
package io_in_filter_pkg;

    localparam int IO_PIN_WIDTH            = 32;
    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

    // Stability counter width; a single-cycle debounce still needs one bit.
    function automatic int cntWidth(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/io_debounce_bit.sv
// One input bit: flop-chain synchroniser, saturating stability counter,
// accepted stable value and registered rise/fall pulses.
module io_debounce_bit
    import io_in_filter_pkg::*;
#(
    parameter int   SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic pin_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int             CW      = cntWidth(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   syn;

    assign syn = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= {SYNC_STAGES{RESET_BIT}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
        end
    end

    // Any cycle where syn agrees with the stable value drops all accumulated credit.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (syn != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = syn;
                rise_d   = syn;
                fall_d   = ~syn;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q    <= '0;
            stable_q <= RESET_BIT;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

// File: rtl/io_in_filter.sv
// Conditions raw FPGA pins for io.io_in: per-bit sync, debounce, edge pulses.
// Optional sticky edge flags with write-one-to-clear when IO_EDGE_LATCH_EN is defined.
module io_in_filter
    import io_in_filter_pkg::*;
#(
    parameter int               WIDTH           = IO_PIN_WIDTH,
    parameter int               SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int               DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] pins_in,
    output logic [WIDTH-1:0] io_in,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    input  logic [WIDTH-1:0] edge_clr,
    output logic [WIDTH-1:0] edge_flags
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        io_debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_BIT      (RESET_VAL[i])
        ) u_bit (
            .clk     (clk),
            .rstn    (rstn),
            .pin_i   (pins_in[i]),
            .stable_o(io_in[i]),
            .rise_o  (rise[i]),
            .fall_o  (fall[i])
        );
    end

`ifdef IO_EDGE_LATCH_EN
    logic [WIDTH-1:0] flags_q, flags_d;

    // A new pulse overrides a clear in the same cycle so no event is lost.
    always_comb begin
        flags_d = (flags_q & ~edge_clr) | rise | fall;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign edge_flags = flags_q;
`else
    logic unused_edge_clr;

    assign unused_edge_clr = ^edge_clr;
    assign edge_flags      = '0;
`endif

endmodule

// File: tb/tb_io_in_filter.sv
// Directed scoreboard bench for io_in_filter (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
module tb_io_in_filter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] pins_in;
    logic [31:0] edge_clr;
    logic [31:0] io_in;
    logic [31:0] rise;
    logic [31:0] fall;
    logic [31:0] edge_flags;

    typedef struct packed {
        logic [31:0] io;
        logic [31:0] rise;
        logic [31:0] fall;
        logic [31:0] flags;
    } exp_t;

    exp_t  sbQ[$];
    string tagQ[$];
    int    errors = 0;
    int    checks = 0;

    logic [31:0] mIo     = '0;
    logic [31:0] mFlags  = '0;
    logic [31:0] mPrevRf = '0;

    io_in_filter #(
        .WIDTH          (32),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .RESET_VAL      (32'h0)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .pins_in   (pins_in),
        .io_in     (io_in),
        .rise      (rise),
        .fall      (fall),
        .edge_clr  (edge_clr),
        .edge_flags(edge_flags)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic resetModel();
        mIo     = '0;
        mFlags  = '0;
        mPrevRf = '0;
    endtask

    // Expected state after the next clock edge; clr is edge_clr driven before that edge.
    task automatic pushExp(input string tag, input logic [31:0] io, input logic [31:0] r,
                           input logic [31:0] f, input logic [31:0] clr);
        logic [31:0] fl;
`ifdef IO_EDGE_LATCH_EN
        fl = (mFlags & ~clr) | mPrevRf;
`else
        fl = '0;
`endif
        mFlags  = fl;
        mPrevRf = r | f;
        sbQ.push_back({io, r, f, fl});
        tagQ.push_back(tag);
    endtask

    task automatic compareField(input string tag, input string field,
                                input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s %s: observed %h expected %h", tag, field, obs, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t  e;
        string tag;
        if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: no expected entry, observed io_in %h", io_in);
            return;
        end
        e   = sbQ.pop_front();
        tag = tagQ.pop_front();
        compareField(tag, "io_in", io_in, e.io);
        compareField(tag, "rise", rise, e.rise);
        compareField(tag, "fall", fall, e.fall);
        compareField(tag, "edge_flags", edge_flags, e.flags);
    endtask

    task automatic applyStimulus(input string tag, input logic [31:0] io, input logic [31:0] r,
                                 input logic [31:0] f, input logic [31:0] clr);
        edge_clr = clr;
        pushExp(tag, io, r, f, clr);
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic hold(input string tag, input int n);
        repeat (n) applyStimulus(tag, mIo, '0, '0, '0);
    endtask

    // Step the pins and expect acceptance on the 6th edge (2 sync + 4 debounce).
    task automatic transition(input string tag, input logic [31:0] newPins,
                              input logic [31:0] clrAtFall);
        logic [31:0] old;
        old     = mIo;
        pins_in = newPins;
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(tag,
                          (k >= 6) ? newPins : old,
                          (k == 6) ? (newPins & ~old) : 32'h0,
                          (k == 6) ? (old & ~newPins) : 32'h0,
                          (k == 7) ? clrAtFall : 32'h0);
        end
        mIo      = newPins;
        edge_clr = '0;
    endtask

    initial begin
        rstn     = 1'b0;
        pins_in  = 32'hFFFF_FFFF;
        edge_clr = '0;
        resetModel();

        // Reset holds everything at RESET_VAL even with all pins high
        hold("reset_hold", 2);
        rstn = 1'b1;
        transition("reset_release", 32'hFFFF_FFFF, '0);
        transition("all_low", 32'h0, '0);

        // Single bit step
        transition("bit0_rise", 32'h1, '0);
        hold("bit0_hold", 2);
        transition("bit0_fall", 32'h0, '0);

        // 3-cycle glitch is discarded
        pins_in[3] = 1'b1;
        hold("glitch3", 3);
        pins_in[3] = 1'b0;
        hold("glitch3", 6);

        // 4-cycle pulse passes through for exactly 4 cycles
        pins_in[3] = 1'b1;
        hold("pulse4", 4);
        pins_in[3] = 1'b0;
        hold("pulse4", 1);
        applyStimulus("pulse4", 32'h8, 32'h8, 32'h0, 32'h0);
        repeat (3) applyStimulus("pulse4", 32'h8, 32'h0, 32'h0, 32'h0);
        applyStimulus("pulse4", 32'h0, 32'h0, 32'h8, 32'h0);
        mIo = '0;
        hold("pulse4", 1);

        // Reset in the middle of a count
        pins_in[5] = 1'b1;
        hold("rst_mid", 4);
        rstn = 1'b0;
        resetModel();
        #1;
        pushExp("rst_async", '0, '0, '0, '0);
        checkOutput();
        applyStimulus("rst_held", '0, '0, '0, '0);
        rstn = 1'b1;
        transition("rst_after", 32'h20, '0);

        // Simultaneous multi-bit changes
        transition("pat_a", 32'hA5A5_0000, '0);
        transition("pat_b", 32'h5A5A_0001, '0);

        // Sticky edge flags: set, clear, and clear colliding with a new fall
        transition("flag_rise", 32'h5A5A_0005, '0);
        hold("flag_hold", 2);
        applyStimulus("flag_clr", mIo, '0, '0, 32'h4);
        edge_clr = '0;
        hold("flag_cleared", 1);
        transition("flag_clr_vs_fall", 32'h5A5A_0001, 32'h4);
        hold("flag_kept", 2);

        if (sbQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: %0d expected entries left unchecked", sbQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
